// File: rtl/cpu_pkg.sv
// Shared definitions for the execute stage: ALU opcodes, multdiv FSM states, iteration count.
// Latency: none (package only).
// Backpressure: none (package only).
package cpu_pkg;

  // ALU opcodes that the single-cycle ALU leaves to the iterative unit
  localparam logic [4:0] MUL = 5'b00110;
  localparam logic [4:0] DIV = 5'b00111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // One radix-2 step per cycle over a 32-bit operand
  localparam int ITER_COUNT = 32;

endpackage

// File: rtl/negate_32.sv
// Conditional two's-complement negate of a 32-bit word, chainable for wider words.
// Latency: combinational.
// Backpressure: none.
// Ports:
//   value     in  32  word to negate
//   en        in  1   1 = negate, 0 = pass through
//   carry_in  in  1   +1 injected into ~value (tie to 1 for a standalone negate)
//   result    out 32  en ? (~value + carry_in) : value
//   carry_out out 1   carry into the next-higher word when en is set, else 0
module negate_32 (
  input  logic [31:0] value,
  input  logic        en,
  input  logic        carry_in,
  output logic [31:0] result,
  output logic        carry_out
);

  logic [32:0] sum;

  assign sum       = {1'b0, ~value} + {32'd0, carry_in};
  assign result    = en ? sum[31:0] : value;
  assign carry_out = en & sum[32];

endmodule

// File: rtl/multdiv_iter.sv
// Iterative signed 32-bit multiply (shift-and-add) / divide (restoring) unit.
// Latency: fixed 33 cycles from the start edge to the one-cycle data_resultRDY pulse.
// Backpressure: none; a new start is accepted in any state and aborts the operation in flight.
// Ports:
//   clock, reset (async, active-low)
//   data_operandA / data_operandB  in  32  multiplicand/dividend, multiplier/divisor
//   ctrl_MULT / ctrl_DIV           in  1   one-cycle start pulses (MULT wins if both)
//   data_result                    out 32  product low word or quotient, held between ops
//   data_exception                 out 1   overflow / divide-by-zero, valid with RDY
//   data_resultRDY                 out 1   one-cycle completion pulse
module multdiv_iter
  import cpu_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] data_operandA,
  input  logic [31:0] data_operandB,
  input  logic        ctrl_MULT,
  input  logic        ctrl_DIV,
  output logic [31:0] data_result,
  output logic        data_exception,
  output logic        data_resultRDY
);

  state_t      state;
  logic [5:0]  count;
  logic [4:0]  op;
  logic        sign;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  // Shared datapath: MUL uses {acc_hi[31:0], acc_lo} as {P_hi, P_lo};
  // DIV uses acc_hi as the 33-bit remainder R and acc_lo as the quotient Q.
  logic [32:0] acc_hi;
  logic [31:0] acc_lo;

  logic        start;
  logic [31:0] a_abs;
  logic [31:0] b_abs;
  logic        a_carry_unused;
  logic        b_carry_unused;

  logic [32:0] mul_sum;
  logic [33:0] div_shift;
  logic [33:0] div_trial;
  logic [32:0] next_hi;
  logic [31:0] next_lo;

  logic [31:0] fix_lo;
  logic [31:0] fix_hi;
  logic        fix_carry;
  logic        fix_carry_unused;
  logic [63:0] product;
  logic        mul_fits;
  logic        div_ovf;

  assign start = ctrl_MULT | ctrl_DIV;

  // Operand magnitudes; |0x80000000| wraps back to 0x80000000, which is the
  // correct unsigned magnitude.
  negate_32 u_abs_a (
    .value     (data_operandA),
    .en        (data_operandA[31]),
    .carry_in  (1'b1),
    .result    (a_abs),
    .carry_out (a_carry_unused)
  );

  negate_32 u_abs_b (
    .value     (data_operandB),
    .en        (data_operandB[31]),
    .carry_in  (1'b1),
    .result    (b_abs),
    .carry_out (b_carry_unused)
  );

  // One iteration step for whichever operation is recorded.
  always_comb begin
    mul_sum   = {1'b0, acc_hi[31:0]} + (acc_lo[0] ? {1'b0, a_mag} : 33'd0);
    div_shift = {acc_hi, acc_lo[31]};
    div_trial = div_shift - {2'b00, b_mag};
    next_hi   = '0;
    next_lo   = '0;
    if (op == DIV) begin
      // Negative trial (bit 33) means restore the shifted remainder.
      next_hi = div_trial[33] ? div_shift[32:0] : div_trial[32:0];
      next_lo = {acc_lo[30:0], ~div_trial[33]};
    end else begin
      next_hi = {1'b0, mul_sum[32:1]};
      next_lo = {mul_sum[0], acc_lo[31:1]};
    end
  end

  // Sign fix: the low instance negates the product low word or the quotient
  // (both live in acc_lo); the high instance finishes the 64-bit product.
  negate_32 u_fix_lo (
    .value     (acc_lo),
    .en        (sign),
    .carry_in  (1'b1),
    .result    (fix_lo),
    .carry_out (fix_carry)
  );

  negate_32 u_fix_hi (
    .value     (acc_hi[31:0]),
    .en        (sign),
    .carry_in  (fix_carry),
    .result    (fix_hi),
    .carry_out (fix_carry_unused)
  );

  assign product  = {fix_hi, fix_lo};
  assign mul_fits = (&product[63:31]) | ~(|product[63:31]);
  // |A| = 2^31 only for A = 0x80000000; |B| = 1 with a positive result sign
  // then forces B = -1.
  assign div_ovf  = (a_mag == 32'h8000_0000) && (b_mag == 32'd1) && !sign;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      count          <= '0;
      op             <= '0;
      sign           <= 1'b0;
      a_mag          <= '0;
      b_mag          <= '0;
      acc_hi         <= '0;
      acc_lo         <= '0;
      data_result    <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
    end else begin
      data_resultRDY <= 1'b0;
      if (start) begin
        // A start always wins, including over a DONE cycle: the aborted
        // operation never raises RDY.
        state  <= RUN;
        count  <= '0;
        op     <= ctrl_MULT ? MUL : DIV;
        sign   <= data_operandA[31] ^ data_operandB[31];
        a_mag  <= a_abs;
        b_mag  <= b_abs;
        acc_hi <= '0;
        acc_lo <= ctrl_MULT ? b_abs : a_abs;
      end else begin
        case (state)
          RUN: begin
            acc_hi <= next_hi;
            acc_lo <= next_lo;
            count  <= count + 6'd1;
            if (count == 6'(ITER_COUNT - 1)) begin
              state <= DONE;
            end
          end
          DONE: begin
            state          <= IDLE;
            data_resultRDY <= 1'b1;
            if (op == DIV) begin
              if (b_mag == 32'd0) begin
                data_result    <= '0;
                data_exception <= 1'b1;
              end else begin
                data_result    <= fix_lo;
                data_exception <= div_ovf;
              end
            end else begin
              data_result    <= fix_lo;
              data_exception <= ~mul_fits;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
